game_ctrl: RTL and testbench

Top-level game sequencer for the ping-pong design. It runs the new-game / play / new-ball / game-over state machine and keeps the two-digit BCD score (`dig0`, `dig1`) and remaining-ball count (`ball_num`) that feed `text`. It drives the freeze and text-select flags that gate `object_ctrl` and the text overlay. All timing is derived from the once-per-frame `update_allow_frist_pluse` tick.

---
 rtl/game_pkg.sv | 19 +
 rtl/game_ctrl_if.sv | 28 ++
 rtl/bcd_score.sv | 52 +++++
 rtl/game_ctrl.sv | 113 +++++++++++
 tb/tb_game_ctrl.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the ping-pong game sequencer.
//   game_state_e : sequencer states, 2-bit encoding
//   DEF_*        : default parameter values for game_ctrl
//   BCD_W        : width of one BCD score digit
package game_pkg;

  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWBALL = 2'd2,
    OVER    = 2'd3
  } game_state_e;

  localparam int DEF_BALLS        = 3;
  localparam int DEF_TIMER_FRAMES = 120;
  localparam int BCD_W            = 4;
  localparam int TIMER_W          = 7;

endpackage

// File: rtl/game_ctrl_if.sv
// Signal bundle between the game sequencer and its surroundings.
//   master : drives frame tick, buttons, hit/miss; receives score/flags
//   slave  : the sequencer side (game_ctrl)
interface game_ctrl_if;
  import game_pkg::*;

  logic               update_allow_frist_pluse;
  logic               up_en;
  logic               down_en;
  logic               hit;
  logic               miss;
  logic [BCD_W-1:0]   dig0;
  logic [BCD_W-1:0]   dig1;
  logic [1:0]         ball_num;
  logic               gra_still;
  logic               show_logo;
  logic               show_over;

  modport master (
    output update_allow_frist_pluse, up_en, down_en, hit, miss,
    input  dig0, dig1, ball_num, gra_still, show_logo, show_over
  );

  modport slave (
    input  update_allow_frist_pluse, up_en, down_en, hit, miss,
    output dig0, dig1, ball_num, gra_still, show_logo, show_over
  );
endinterface

// File: rtl/bcd_score.sv
// Two-digit BCD score counter, saturating at 99.
//   clk, rst  : clock, async active-low reset
//   clr_i     : synchronous clear to 00 (wins over inc_i)
//   inc_i     : add one
//   dig0_o    : units digit, dig1_o : tens digit
module bcd_score
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [BCD_W-1:0] dig0_o,
  output logic [BCD_W-1:0] dig1_o
);

  logic [BCD_W-1:0] dig0_q, dig0_d;
  logic [BCD_W-1:0] dig1_q, dig1_d;
  logic             at_max;

  assign at_max = (dig0_q == 4'd9) && (dig1_q == 4'd9);

  always_comb begin
    dig0_d = dig0_q;
    dig1_d = dig1_q;
    if (clr_i) begin
      dig0_d = '0;
      dig1_d = '0;
    end else if (inc_i && !at_max) begin
      if (dig0_q == 4'd9) begin
        dig0_d = '0;
        dig1_d = dig1_q + 4'd1;
      end else begin
        dig0_d = dig0_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dig0_q <= '0;
      dig1_q <= '0;
    end else begin
      dig0_q <= dig0_d;
      dig1_q <= dig1_d;
    end
  end

  assign dig0_o = dig0_q;
  assign dig1_o = dig1_q;

endmodule

// File: rtl/game_ctrl.sv
// Ping-pong game sequencer: new-game / play / new-ball / game-over FSM,
// pause timer, remaining-ball counter and BCD score.
//   clk, rst : clock, async active-low reset
//   gif      : game_ctrl_if.slave - frame tick, buttons, hit/miss in;
//              score digits, ball count and display flags out
module game_ctrl
  import game_pkg::*;
#(
  parameter int BALLS        = DEF_BALLS,
  parameter int TIMER_FRAMES = DEF_TIMER_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  game_ctrl_if.slave  gif
);

  localparam logic [1:0]         BALLS_L = 2'(BALLS);
  localparam logic [TIMER_W-1:0] TIMER_L = TIMER_W'(TIMER_FRAMES);

  game_state_e        state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         ball_q, ball_d;
  logic               gra_still_q, gra_still_d;
  logic               show_logo_q, show_logo_d;
  logic               show_over_q, show_over_d;
  logic               btn, timer_load, score_clr, score_inc;

  assign btn = gif.up_en | gif.down_en;

  // State, timer, ball count and flags share one register process.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= NEWGAME;
      timer_q     <= '0;
      ball_q      <= BALLS_L;
      gra_still_q <= 1'b1;
      show_logo_q <= 1'b1;
      show_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      ball_q      <= ball_d;
      gra_still_q <= gra_still_d;
      show_logo_q <= show_logo_d;
      show_over_q <= show_over_d;
    end
  end

  // Next state plus the datapath actions tied to transitions.
  always_comb begin
    state_d    = state_q;
    ball_d     = ball_q;
    timer_load = 1'b0;
    score_clr  = 1'b0;
    score_inc  = 1'b0;
    unique case (state_q)
      NEWGAME: if (btn) begin
        state_d   = PLAY;
        score_clr = 1'b1;
        ball_d    = BALLS_L;
      end
      PLAY: begin
        // miss dominates a coincident hit
        if (gif.miss) begin
          timer_load = 1'b1;
          if (ball_q > 2'd1) begin
            ball_d  = ball_q - 2'd1;
            state_d = NEWBALL;
          end else begin
            ball_d  = 2'd0;
            state_d = OVER;
          end
        end else if (gif.hit) begin
          score_inc = 1'b1;
        end
      end
      NEWBALL: if (timer_q == '0 && btn) state_d = PLAY;
      OVER:    if (timer_q == '0)        state_d = NEWGAME;
      default: state_d = NEWGAME;
    endcase
  end

  // Load beats decrement, so a tick in the load cycle is not counted.
  always_comb begin
    timer_d = timer_q;
    if (timer_load)
      timer_d = TIMER_L;
    else if (gif.update_allow_frist_pluse && timer_q != '0)
      timer_d = timer_q - 1'b1;
  end

  // Flags decoded from the next state so they move with the state register.
  always_comb begin
    gra_still_d = (state_d != PLAY);
    show_logo_d = (state_d == NEWGAME);
    show_over_d = (state_d == OVER);
  end

  bcd_score u_score (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (score_clr),
    .inc_i  (score_inc),
    .dig0_o (gif.dig0),
    .dig1_o (gif.dig1)
  );

  assign gif.ball_num  = ball_q;
  assign gif.gra_still = gra_still_q;
  assign gif.show_logo = show_logo_q;
  assign gif.show_over = show_over_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl (BALLS=3, TIMER_FRAMES=120).
module tb_game_ctrl;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  game_ctrl_if gif ();

  game_ctrl #(.BALLS(3), .TIMER_FRAMES(120)) dut (
    .clk (clk),
    .rst (rst),
    .gif (gif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are read 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      gif.hit = 1'b1; cyc(); gif.hit = 1'b0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      gif.update_allow_frist_pluse = 1'b1; cyc();
      gif.update_allow_frist_pluse = 1'b0;
    end
  endtask

  task automatic miss1();
    gif.miss = 1'b1; cyc(); gif.miss = 1'b0;
  endtask

  task automatic score(input string tag, input int tens, input int units);
    chk({tag, "_dig1"}, 32'(gif.dig1), 32'(tens));
    chk({tag, "_dig0"}, 32'(gif.dig0), 32'(units));
  endtask

  // from NEWBALL with a fresh 120-frame load, button held throughout
  task automatic resume(input string tag);
    gif.down_en = 1'b1;
    ticks(119);
    cyc();
    chk({tag, "_still_119"}, 32'(gif.gra_still), 1);
    ticks(1);
    chk({tag, "_still_120"}, 32'(gif.gra_still), 1);
    cyc();
    chk({tag, "_play"}, 32'(gif.gra_still), 0);
    gif.down_en = 1'b0;
  endtask

  initial begin
    gif.update_allow_frist_pluse = 1'b0;
    gif.up_en   = 1'b0;
    gif.down_en = 1'b0;
    gif.hit     = 1'b0;
    gif.miss    = 1'b0;
    repeat (3) cyc();

    // reset values
    score("rst", 0, 0);
    chk("rst_ball", 32'(gif.ball_num), 3);
    chk("rst_still", 32'(gif.gra_still), 1);
    chk("rst_logo", 32'(gif.show_logo), 1);
    chk("rst_over", 32'(gif.show_over), 0);

    // release with button held: PLAY after one edge
    rst = 1'b1;
    gif.up_en = 1'b1;
    cyc();
    gif.up_en = 1'b0;
    chk("start_still", 32'(gif.gra_still), 0);
    chk("start_logo", 32'(gif.show_logo), 0);
    chk("start_ball", 32'(gif.ball_num), 3);
    score("start", 0, 0);

    // 12 hits -> 12, BCD carry
    hits(12);
    score("hit12", 1, 2);

    // first miss -> NEWBALL, 2 balls
    miss1();
    chk("miss1_ball", 32'(gif.ball_num), 2);
    chk("miss1_still", 32'(gif.gra_still), 1);
    chk("miss1_over", 32'(gif.show_over), 0);
    resume("nb1");

    // second miss -> 1 ball
    miss1();
    chk("miss2_ball", 32'(gif.ball_num), 1);
    resume("nb2");

    // third miss with coincident hit -> OVER, hit dropped
    gif.hit = 1'b1; miss1(); gif.hit = 1'b0;
    chk("miss3_ball", 32'(gif.ball_num), 0);
    chk("miss3_over", 32'(gif.show_over), 1);
    chk("miss3_still", 32'(gif.gra_still), 1);
    score("miss3", 1, 2);

    // button ignored in OVER; NEWGAME after 120 ticks, score held
    gif.up_en = 1'b1;
    ticks(119);
    cyc();
    chk("over_119", 32'(gif.show_over), 1);
    gif.up_en = 1'b0;
    ticks(1);
    cyc();
    chk("ng_logo", 32'(gif.show_logo), 1);
    chk("ng_over", 32'(gif.show_over), 0);
    score("ng_held", 1, 2);

    // new game clears score and reloads balls
    gif.down_en = 1'b1; cyc(); gif.down_en = 1'b0;
    score("ng2", 0, 0);
    chk("ng2_ball", 32'(gif.ball_num), 3);
    chk("ng2_still", 32'(gif.gra_still), 0);

    // hit+miss together at 05
    hits(5);
    score("h5", 0, 5);
    gif.hit = 1'b1; miss1(); gif.hit = 1'b0;
    score("hm", 0, 5);
    chk("hm_ball", 32'(gif.ball_num), 2);
    resume("nb3");

    // hits outside PLAY ignored later; drive to 98, then saturate at 99
    hits(93);
    score("s98", 9, 8);
    hits(3);
    score("s99", 9, 9);

    // miss -> NEWBALL, 60 ticks in, then async reset between edges
    miss1();
    chk("miss4_ball", 32'(gif.ball_num), 1);
    hits(2);
    score("nb_hit_ignored", 9, 9);
    ticks(60);
    #2;
    rst = 1'b0;
    #1;
    score("arst", 0, 0);
    chk("arst_ball", 32'(gif.ball_num), 3);
    chk("arst_still", 32'(gif.gra_still), 1);
    chk("arst_logo", 32'(gif.show_logo), 1);
    chk("arst_over", 32'(gif.show_over), 0);

    // after release, still NEWGAME until a button press
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("post_logo", 32'(gif.show_logo), 1);
    gif.up_en = 1'b1; cyc(); gif.up_en = 1'b0;
    chk("post_play", 32'(gif.gra_still), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
